register_file: RTL

Register file for the RISC datapath: 32 general registers, two combinational read ports (rs, rt) and one synchronous write port whose address comes from the destination-register select path. It sits between decode and write-back. A busy-bit scoreboard is set when an instruction issues with a destination and cleared when that destination is written back. Register 0 always reads as zero and is never busy.

---
 rtl/rf_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 57 +++++
 rtl/register_file.sv | 89 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared sizing and types for the register file and its busy-bit scoreboard.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : rf_pkg

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, set on issue and
// cleared on write-back. Register 0 never becomes busy.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: a new issue beats a write-back to the same register,
    // since the freshly issued producer is still in flight.
    always_comb begin
        busy_d = busy_q;
        for (int a = 1; a < NREGS; a++) begin
            if (issue_en && (issue_addr == ADDR_W'(a))) begin
                busy_d[a] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(a))) begin
                busy_d[a] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy bit storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Query ports: a write-back this cycle masks busy because its data is bypassed.
    always_comb begin
        rs_busy = (rs_addr != ZERO_ADDR) && busy_q[rs_addr] &&
                  !(wr_en && (wr_addr == rs_addr));
        rt_busy = (rt_addr != ZERO_ADDR) && busy_q[rt_addr] &&
                  !(wr_en && (wr_addr == rt_addr));
    end

endmodule : reg_scoreboard

// File: rtl/register_file.sv
// 2-read / 1-write register file with write bypass, hardwired zero register
// and a busy-bit scoreboard for pending write-backs.
module register_file
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    // Register 0 has no storage; it is synthesised as a constant on read.
    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic [DATA_W-1:0] regs_d [1:NREGS-1];

    // Read mux for one port: zero register, then write bypass, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] store [1:NREGS-1]
    );
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr == ZERO_ADDR) begin
            val = '0;
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = store[addr];
        end
        return val;
    endfunction

    // Write decode: writes targeting register 0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != ZERO_ADDR)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Register storage; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports with write-back bypass.
    always_comb begin
        rs_data = read_port(rs_addr, wr_en, wr_addr, wr_data, regs_q);
        rt_data = read_port(rt_addr, wr_en, wr_addr, wr_data, regs_q);
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy)
    );

endmodule : register_file
